// File: rtl/mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mem_access_stage                                             |
// | Description : Pipeline memory-access stage. It owns a DEPTH x 64-bit data   |
// |               memory with a LATENCY-cycle access time and produces one     |
// |               writeback beat per accepted instruction.                     |
// |               Optional: `define MISALIGN_TRAP_EN to trap misaligned ops.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mem_access_stage #(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] alu_result,
    input  logic [63:0] rd2,
    input  logic [4:0]  write_addr,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        MemtoReg,
    input  logic        RegWrite,
    output logic        wb_valid,
    output logic [63:0] wb_data,
    output logic [4:0]  wb_addr,
    output logic        wb_RegWrite,
    output logic        busy,
    output logic        misalign
);

    localparam int         c_AW   = $clog2(DEPTH);
    localparam logic [2:0] c_LAT  = 3'(LATENCY);
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]      r_state;
    logic [1:0]      w_state_nxt;
    logic [2:0]      r_cnt;
    logic            r_is_wr;
    logic            r_is_ld;
    logic            r_regwrite;
    logic [c_AW-1:0] r_idx;
    logic [63:0]     r_alu;
    logic [63:0]     r_wdata;
    logic [4:0]      r_waddr;
    logic            r_misalign;
    logic [63:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_misalign;
    logic            w_mem_op;
    logic            w_done;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = (MemRead | MemWrite) & (alu_result[2:0] != 3'd0);
`else
    assign w_misalign = 1'b0;
`endif

    assign w_mem_op = (MemRead | MemWrite) & ~w_misalign;
    assign w_accept = in_valid & in_ready;
    // r_cnt counts edges since accept; the access completes on edge k+LATENCY.
    assign w_done   = (r_state == c_WAIT) && (r_cnt == c_LAT);

    assign in_ready = (r_state != c_WAIT);
    assign busy     = (r_state == c_WAIT);
    assign wb_valid = (r_state == c_RESP);
    assign misalign = r_misalign;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_WAIT: begin
                if (w_done) begin
                    w_state_nxt = c_RESP;
                end
            end
            c_IDLE, c_RESP: begin
                if (w_accept) begin
                    w_state_nxt = w_mem_op ? c_WAIT : c_RESP;
                end else begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= 3'd0;
            r_is_wr     <= 1'b0;
            r_is_ld     <= 1'b0;
            r_regwrite  <= 1'b0;
            r_idx       <= '0;
            r_alu       <= 64'd0;
            r_wdata     <= 64'd0;
            r_waddr     <= 5'd0;
            r_misalign  <= 1'b0;
            wb_data     <= 64'd0;
            wb_addr     <= 5'd0;
            wb_RegWrite <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt      <= 3'd1;
                r_is_wr    <= MemWrite;
                r_is_ld    <= MemRead & MemtoReg & ~MemWrite;
                r_regwrite <= RegWrite & (write_addr != 5'd0);
                r_idx      <= alu_result[3 +: c_AW];
                r_alu      <= alu_result;
                r_wdata    <= rd2;
                r_waddr    <= write_addr;
            end else if (r_state == c_WAIT) begin
                r_cnt <= r_cnt + 3'd1;
            end

            // Writeback fields change only on entry to RESP and hold otherwise.
            if (w_accept && !w_mem_op) begin
                wb_data     <= alu_result;
                wb_addr     <= write_addr;
                wb_RegWrite <= RegWrite & (write_addr != 5'd0) & ~w_misalign;
            end else if (w_done) begin
                wb_data     <= r_is_ld ? r_mem[r_idx] : r_alu;
                wb_addr     <= r_waddr;
                wb_RegWrite <= r_regwrite;
            end

            r_misalign <= w_accept & w_misalign;
        end
    end

    // Memory is never reset; a reset during WAIT clears r_state, so w_done never fires.
    always_ff @(posedge clk) begin
        if (w_done && r_is_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mem_access_stage                                          |
// | Description : Self-checking bench for mem_access_stage with a behavioural  |
// |               memory/timing reference model. Honours MISALIGN_TRAP_EN.     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mem_access_stage;

    localparam int DEPTH   = 128;
    localparam int LATENCY = 2;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] alu_result;
    logic [63:0] rd2;
    logic [4:0]  write_addr;
    logic        MemRead, MemWrite, MemtoReg, RegWrite;
    logic        wb_valid;
    logic [63:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_RegWrite;
    logic        busy;
    logic        misalign;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [63:0] ref_mem [DEPTH];
    logic [63:0] last_data;
    logic [4:0]  last_addr;
    logic        last_rw;

    mem_access_stage #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .rd2        (rd2),
        .write_addr (write_addr),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .wb_valid   (wb_valid),
        .wb_data    (wb_data),
        .wb_addr    (wb_addr),
        .wb_RegWrite(wb_RegWrite),
        .busy       (busy),
        .misalign   (misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one instruction at a falling edge and check its whole response window.
    task automatic do_op(input bit mr, input bit mw, input bit mtr, input bit rw,
                         input logic [4:0] wa, input logic [63:0] alu, input logic [63:0] d);
        bit          mis;
        bit          memop;
        int          wait_cycles;
        int          idx;
        logic [63:0] exp_data;
        mis         = TRAP && (mr || mw) && (alu[2:0] != 3'd0);
        memop       = (mr || mw) && !mis;
        wait_cycles = memop ? LATENCY : 0;
        idx         = int'((alu >> 3) % DEPTH);
        exp_data    = (memop && mr && mtr && !mw) ? ref_mem[idx] : alu;
        if (memop && mw) ref_mem[idx] = d;

        check("ready_before_accept", in_ready, 1);
        in_valid = 1'b1; MemRead = mr; MemWrite = mw; MemtoReg = mtr; RegWrite = rw;
        write_addr = wa; alu_result = alu; rd2 = d;
        @(negedge clk);
        in_valid = 1'b0;
        for (int j = 1; j <= wait_cycles; j++) begin
            check("wait_busy", busy, 1);
            check("wait_in_ready", in_ready, 0);
            check("wait_wb_valid", wb_valid, 0);
            @(negedge clk);
        end
        check("resp_wb_valid", wb_valid, 1);
        check("resp_wb_data", wb_data, exp_data);
        check("resp_wb_addr", wb_addr, wa);
        check("resp_wb_regwrite", wb_RegWrite, rw && (wa != 5'd0) && !mis);
        check("resp_misalign", misalign, mis);
        check("resp_busy", busy, 0);
        last_data = exp_data;
        last_addr = wa;
        last_rw   = rw && (wa != 5'd0) && !mis;
    endtask

    task automatic idle_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        check("idle_wb_valid", wb_valid, 0);
        check("idle_in_ready", in_ready, 1);
        check("idle_misalign", misalign, 0);
        check("hold_wb_data", wb_data, last_data);
        check("hold_wb_addr", wb_addr, last_addr);
        check("hold_wb_regwrite", wb_RegWrite, last_rw);
    endtask

    initial begin
        logic [63:0] a;
        rst_n = 1'b0; in_valid = 1'b0; alu_result = '0; rd2 = '0; write_addr = '0;
        MemRead = 0; MemWrite = 0; MemtoReg = 0; RegWrite = 0;
        last_data = '0; last_addr = '0; last_rw = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_wb_valid", wb_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_misalign", misalign, 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_addr", wb_addr, 0);
        check("rst_wb_regwrite", wb_RegWrite, 0);
        rst_n = 1'b1;
        idle_cycle();

        // Fill every word so later loads have defined contents.
        for (int i = 0; i < DEPTH; i++) do_op(0, 1, 0, 0, 5'd0, 64'(i * 8), {$urandom, $urandom});
        idle_cycle();

        do_op(0, 0, 0, 1, 5'd7, 64'h2A, 64'h0);
        do_op(0, 1, 0, 0, 5'd0, 64'h10, 64'hDEADBEEF);
        do_op(1, 0, 1, 1, 5'd5, 64'h10, 64'h0);
        do_op(0, 0, 0, 1, 5'd0, 64'h55, 64'h0);
        do_op(0, 0, 0, 1, 5'd3, 64'h99, 64'h0);
        idle_cycle();
        do_op(0, 1, 0, 0, 5'd0, 64'h400, 64'h55);
        do_op(1, 0, 1, 1, 5'd3, 64'h0, 64'h0);
        do_op(1, 1, 1, 1, 5'd4, 64'h18, 64'h1234);
        do_op(1, 0, 1, 1, 5'd4, 64'h18, 64'h0);
        do_op(1, 0, 1, 1, 5'd9, 64'h13, 64'h0);
        idle_cycle();

        // Reset in the middle of a store's WAIT window must abort the write.
        in_valid = 1'b1; MemRead = 0; MemWrite = 1; MemtoReg = 0; RegWrite = 0;
        write_addr = 5'd0; alu_result = 64'h8; rd2 = 64'h77;
        @(negedge clk);
        in_valid = 1'b0;
        check("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_in_ready", in_ready, 1);
        check("async_rst_wb_data", wb_data, 0);
        check("async_rst_wb_regwrite", wb_RegWrite, 0);
        @(negedge clk);
        rst_n = 1'b1;
        last_data = '0; last_addr = '0; last_rw = 1'b0;
        repeat (3) idle_cycle();
        do_op(1, 0, 1, 1, 5'd6, 64'h8, 64'h0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(3) == 0) idle_cycle();
            a = {$urandom, $urandom};
            if ($urandom_range(3) != 0) a[2:0] = 3'd0;
            if ($urandom_range(1) == 0) a = a & 64'hFFF;
            do_op(1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  1'($urandom_range(1)), 5'($urandom), a, {$urandom, $urandom});
        end
        idle_cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
